rr_arb_lock: RTL

Parametrised round-robin arbiter with a registered one-hot grant and a lock until the granted master signals end of transaction. It is the successor to the single-cycle request/number arbiter. The pointer advances past the actual winner, giving true round-robin fairness. Grants are held across multi-cycle transfers, and back-to-back regrant happens with no bubble. It sits between REQCNT masters and one shared slave or bus port.

---
 rtl/rr_arb_pkg.sv | 13 +
 rtl/rr_arb_lock_pick.sv | 23 ++
 rtl/rr_arb_lock.sv | 108 ++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types, limits and index helper for the lockable round-robin arbiter
package rr_arb_pkg;

    typedef enum logic {IDLE, BUSY} rr_state_t;

    localparam int MAX_REQCNT = 32;

    // Wrap-around increment against the requester count, not the index width
    function automatic int next_idx(input int idx, input int cnt);
        return (idx + 1 >= cnt) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arb_lock_pick.sv
// rr_pick: combinational cyclic first-set-bit search starting at ptr
module rr_pick #(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT)
) (
    input  logic [REQCNT-1:0]   req,
    input  logic [REQWIDTH-1:0] ptr,
    output logic                hit,
    output logic [REQWIDTH-1:0] idx
);

    logic [2*REQCNT-1:0] masked;

    // Lower copy is masked below ptr, so the lowest set bit of the doubled vector is the cyclic winner
    always_comb begin
        masked = {req, req} & ({(2*REQCNT){1'b1}} << ptr);
        hit    = |req;
        idx    = '0;
        for (int i = 2*REQCNT-1; i >= 0; i--)
            if (masked[i]) idx = (i >= REQCNT) ? REQWIDTH'(i - REQCNT) : REQWIDTH'(i);
    end

endmodule

// File: rtl/rr_arb_lock.sv
// rr_arb_lock: round-robin arbiter with registered one-hot grant held until done_i
// Optional per-master grant budgets are enabled by defining RR_ARB_WEIGHT_EN.
module rr_arb_lock
    import rr_arb_pkg::*;
#(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int WEIGHTW  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REQCNT-1:0]         req_i,
    input  logic                      done_i,
`ifdef RR_ARB_WEIGHT_EN
    input  logic [REQCNT*WEIGHTW-1:0] weight_i,
`endif
    output logic [REQCNT-1:0]         gnt_o,
    output logic [REQWIDTH-1:0]       gnt_num_o,
    output logic                      gnt_val_o
);

    if (REQCNT < 2 || REQCNT > MAX_REQCNT || WEIGHTW < 1) begin : g_bad_cfg
        $error("rr_arb_lock: unsupported parameters");
    end

    rr_state_t           state, state_nx;
    logic [REQWIDTH-1:0] ptr, ptr_nx, adv, pick_ptr, pick_idx, win, num_nx;
    logic [REQCNT-1:0]   gnt_nx;
    logic                val_nx, hit, keep;

    // The current winner is exactly the registered grant index
    assign win      = gnt_num_o;
    assign adv      = REQWIDTH'(next_idx(int'(win), REQCNT));
    assign pick_ptr = (state == BUSY) ? adv : ptr;

    rr_pick #(.REQCNT(REQCNT), .REQWIDTH(REQWIDTH)) u_pick (
        .req (req_i),
        .ptr (pick_ptr),
        .hit (hit),
        .idx (pick_idx)
    );

`ifdef RR_ARB_WEIGHT_EN
    logic [WEIGHTW-1:0] credit, wfield, wt;

    assign wfield = weight_i[win*WEIGHTW +: WEIGHTW];
    assign wt     = (wfield == '0) ? WEIGHTW'(1) : wfield;
    assign keep   = req_i[win] && (credit < wt);

    // Credit counts grants given to the current winner in a row; restarts at 1 for every new winner
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            credit <= WEIGHTW'(1);
        else if (state == IDLE)
            credit <= WEIGHTW'(1);
        else if (done_i)
            credit <= keep ? credit + WEIGHTW'(1) : WEIGHTW'(1);
    end
`else
    assign keep = 1'b0;
`endif

    // Next state: grant from idle, hold while busy, hand off or release on done_i
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        gnt_nx   = gnt_o;
        num_nx   = gnt_num_o;
        val_nx   = gnt_val_o;
        if (state == IDLE) begin
            if (hit) begin
                state_nx = BUSY;
                gnt_nx   = REQCNT'(1) << pick_idx;
                num_nx   = pick_idx;
                val_nx   = 1'b1;
            end
        end else if (done_i && !keep) begin
            ptr_nx = adv;
            if (hit) begin
                gnt_nx = REQCNT'(1) << pick_idx;
                num_nx = pick_idx;
            end else begin
                state_nx = IDLE;
                gnt_nx   = '0;
                num_nx   = '0;
                val_nx   = 1'b0;
            end
        end
    end

    // State and grant registers; reset drops any grant immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_o     <= '0;
            gnt_num_o <= '0;
            gnt_val_o <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            gnt_o     <= gnt_nx;
            gnt_num_o <= num_nx;
            gnt_val_o <= val_nx;
        end
    end

endmodule
